// File: rtl/ft64_regfile_nwmr_lvt.sv
// Multi-write, multi-read register file: NW write banks with a per-byte-lane live-value table.
// Optional macro FT64_RF_BYPASS_EN adds same-cycle write forwarding onto the read ports.
module ft64_regfile_nwmr_lvt #(
  parameter int WID   = 64,
  parameter int RBIT  = 7,
  parameter int NW    = 2,
  parameter int NR    = 6,
  parameter int ZERO5 = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NW-1:0]                wr,
  input  logic [NW*(WID/8)-1:0]        we,
  input  logic [NW*(RBIT+1)-1:0]       wa,
  input  logic [NW*WID-1:0]            i,
  input  logic [NR*(RBIT+1)-1:0]       ra,
  output logic [NR*WID-1:0]            o
);

  localparam int NB = WID / 8;
  localparam int AW = RBIT + 1;
  localparam int D  = 2 ** AW;
  localparam int LB = (NW > 1) ? $clog2(NW) : 1;

  logic [AW-1:0]  wa_p [NW];
  logic [WID-1:0] i_p  [NW];
  logic [NB-1:0]  we_p [NW];
  logic [AW-1:0]  ra_p [NR];

  always_comb begin
    for (int p = 0; p < NW; p++) begin
      wa_p[p] = wa[p*AW +: AW];
      i_p[p]  = i[p*WID +: WID];
      we_p[p] = we[p*NB +: NB];
    end
    for (int k = 0; k < NR; k++) begin
      ra_p[k] = ra[k*AW +: AW];
    end
  end

  logic [AW-1:0] ra_q [NR];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NR; k++) ra_q[k] <= '0;
    end else begin
      for (int k = 0; k < NR; k++) ra_q[k] <= ra_p[k];
    end
  end

  // Live-value table: which bank holds the newest copy of each byte lane.
  logic [LB-1:0] lvt  [D][NB];
  logic [NB-1:0] lval [D];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < D; a++) begin
        lval[a] <= '0;
        for (int b = 0; b < NB; b++) lvt[a][b] <= '0;
      end
    end else begin
      // Ascending port order: the highest-numbered port lands last and wins.
      for (int p = 0; p < NW; p++) begin
        for (int b = 0; b < NB; b++) begin
          if (wr[p] && we_p[p][b]) begin
            lvt[wa_p[p]][b]  <= LB'(p);
            lval[wa_p[p]][b] <= 1'b1;
          end
        end
      end
    end
  end

  // Bank contents are never cleared; stale data is hidden by lval.
  logic [WID-1:0] bank [NW][D];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < NW; p++) begin
        for (int b = 0; b < NB; b++) begin
          if (wr[p] && we_p[p][b]) begin
            bank[p][wa_p[p]][b*8 +: 8] <= i_p[p][b*8 +: 8];
          end
        end
      end
    end
  end

  logic [WID-1:0] rd [NR];

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      rd[k] = '0;
      for (int b = 0; b < NB; b++) begin
        if (lval[ra_q[k]][b]) begin
          rd[k][b*8 +: 8] = bank[lvt[ra_q[k]][b]][ra_q[k]][b*8 +: 8];
        end
`ifdef FT64_RF_BYPASS_EN
        for (int p = 0; p < NW; p++) begin
          if (!rst && wr[p] && we_p[p][b] && (wa_p[p] == ra_q[k])) begin
            rd[k][b*8 +: 8] = i_p[p][b*8 +: 8];
          end
        end
`endif
      end
      // r0 of every 32-entry register set is hardwired to zero.
      if ((ZERO5 != 0) && (ra_q[k][4:0] == 5'd0)) begin
        rd[k] = '0;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < NR; k++) begin
      o[k*WID +: WID] = rd[k];
    end
  end

endmodule

// File: tb/tb_ft64_regfile_nwmr_lvt.sv
// Self-checking bench for ft64_regfile_nwmr_lvt: directed cases plus randomized traffic
// compared each cycle against a value/valid-mask memory model.
module tb_ft64_regfile_nwmr_lvt;

  localparam int WID = 64;
  localparam int NW  = 2;
  localparam int NR  = 6;
  localparam int NB  = 8;
  localparam int AW  = 8;
  localparam int D   = 256;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NW-1:0]        wr;
  logic [NW*NB-1:0]     we;
  logic [NW*AW-1:0]     wa;
  logic [NW*WID-1:0]    i;
  logic [NR*AW-1:0]     ra;
  logic [NR*WID-1:0]    o;

  int checks = 0;
  int errors = 0;

  logic [WID-1:0] m_data [D];
  logic [NB-1:0]  m_val  [D];
  logic [AW-1:0]  m_ra   [NR];

  ft64_regfile_nwmr_lvt #(
    .WID(WID), .RBIT(AW-1), .NW(NW), .NR(NR), .ZERO5(1)
  ) dut (
    .clk(clk), .rst(rst), .wr(wr), .we(we), .wa(wa), .i(i), .ra(ra), .o(o)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int a = 0; a < D; a++) m_val[a] = '0;
    for (int k = 0; k < NR; k++) m_ra[k] = '0;
  endtask

  task automatic model_commit();
    logic [AW-1:0] a;
    if (!rst) begin
      for (int p = 0; p < NW; p++) begin
        if (wr[p]) begin
          a = wa[p*AW +: AW];
          for (int b = 0; b < NB; b++) begin
            if (we[p*NB + b]) begin
              m_data[a][b*8 +: 8] = i[p*WID + b*8 +: 8];
              m_val[a][b] = 1'b1;
            end
          end
        end
      end
      for (int k = 0; k < NR; k++) m_ra[k] = ra[k*AW +: AW];
    end
  endtask

  function automatic logic [WID-1:0] expect_rd(input int k);
    logic [AW-1:0]  a;
    logic [WID-1:0] v;
    a = m_ra[k];
    v = '0;
    for (int b = 0; b < NB; b++) begin
      if (m_val[a][b]) v[b*8 +: 8] = m_data[a][b*8 +: 8];
    end
`ifdef FT64_RF_BYPASS_EN
    for (int p = 0; p < NW; p++) begin
      for (int b = 0; b < NB; b++) begin
        if (!rst && wr[p] && we[p*NB + b] && wa[p*AW +: AW] == a)
          v[b*8 +: 8] = i[p*WID + b*8 +: 8];
      end
    end
`endif
    if (a[4:0] == 5'd0) v = '0;
    return v;
  endfunction

  task automatic compare_all();
    logic [WID-1:0] exp_v;
    logic [WID-1:0] act_v;
    for (int k = 0; k < NR; k++) begin
      exp_v = expect_rd(k);
      act_v = o[k*WID +: WID];
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL read%0d addr=%h got %h expected %h t=%0t", k, m_ra[k], act_v, exp_v, $time);
      end
    end
  endtask

  task automatic lit(input string name, input logic [WID-1:0] act_v, input logic [WID-1:0] exp_v);
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act_v, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_commit();
  endtask

  task automatic cmp();
    #1;
    compare_all();
  endtask

  task automatic set_wr(input int p, input logic [AW-1:0] a, input logic [NB-1:0] m, input logic [WID-1:0] d);
    wr[p] = 1'b1;
    we[p*NB +: NB] = m;
    wa[p*AW +: AW] = a;
    i[p*WID +: WID] = d;
  endtask

  task automatic clr_wr();
    wr = '0;
    we = '0;
  endtask

  task automatic set_ra(input int k, input logic [AW-1:0] a);
    ra[k*AW +: AW] = a;
  endtask

  logic [AW-1:0] pool [8];

  initial begin
    pool = '{8'h00, 8'h20, 8'h21, 8'h05, 8'h07, 8'h09, 8'h0A, 8'hE3};
    wr = '0; we = '0; wa = '0; i = '0; ra = '0;
    model_reset();
    #1 rst = 1'b1;
    tick();
    tick();
    cmp();
    lit("reset_o", o[WID-1:0], 64'h0);
    rst = 1'b0;

    // basic write/read, same-cycle address
    set_wr(0, 8'h05, 8'hFF, 64'hDEADBEEFCAFEF00D);
    for (int k = 0; k < NR; k++) set_ra(k, 8'h05);
    cmp();
    tick(); clr_wr(); cmp();
    lit("basic_o1", o[1*WID +: WID], 64'hDEADBEEFCAFEF00D);
    lit("basic_o5", o[5*WID +: WID], 64'hDEADBEEFCAFEF00D);

    // byte merge across ports
    set_wr(0, 8'h07, 8'hFF, 64'hAAAAAAAAAAAAAAAA);
    set_ra(0, 8'h07);
    cmp(); tick(); clr_wr();
    set_wr(1, 8'h07, 8'h0F, 64'h00000000BBBBBBBB);
    cmp(); tick(); clr_wr(); cmp();
    lit("merge", o[0 +: WID], 64'hAAAAAAAABBBBBBBB);

    // same-address collision
    set_wr(0, 8'h09, 8'hFF, 64'h1);
    set_wr(1, 8'h09, 8'hFF, 64'h2);
    set_ra(0, 8'h09);
    cmp(); tick(); clr_wr(); cmp();
    lit("collide_full", o[0 +: WID], 64'h2);
    set_wr(0, 8'h09, 8'hF0, 64'hFFFFFFFFFFFFFFFF);
    set_wr(1, 8'h09, 8'h0F, 64'h0);
    cmp(); tick(); clr_wr(); cmp();
    lit("collide_lane", o[0 +: WID], 64'hFFFFFFFF00000000);

    // zero5 override
    set_wr(0, 8'h20, 8'hFF, 64'h1234);
    set_wr(1, 8'h00, 8'hFF, 64'h1234);
    set_ra(0, 8'h20); set_ra(1, 8'h00);
    cmp(); tick(); clr_wr(); cmp();
    lit("zero5_20", o[0 +: WID], 64'h0);
    lit("zero5_00", o[1*WID +: WID], 64'h0);
    set_wr(0, 8'h21, 8'hFF, 64'h1234);
    set_ra(2, 8'h21);
    cmp(); tick(); clr_wr(); cmp();
    lit("zero5_21", o[2*WID +: WID], 64'h1234);

    // reset masks written data; writes during reset dropped
    set_wr(0, 8'h21, 8'hFF, 64'h1122334455667788);
    set_ra(0, 8'h21);
    cmp(); tick(); clr_wr(); cmp();
    lit("pre_rst", o[0 +: WID], 64'h1122334455667788);
    rst = 1'b1; model_reset();
    set_wr(1, 8'h21, 8'hFF, 64'h99);
    cmp();
    lit("in_rst", o[0 +: WID], 64'h0);
    tick(); cmp();
    lit("in_rst_wr", o[0 +: WID], 64'h0);
    rst = 1'b0; clr_wr();
    cmp(); tick(); cmp();
    lit("post_rst", o[0 +: WID], 64'h0);
    set_wr(0, 8'h21, 8'h03, 64'hABCD);
    cmp(); tick(); clr_wr(); cmp();
    lit("rewrite", o[0 +: WID], 64'hABCD);

    // forwarding behaviour
    set_wr(0, 8'h0A, 8'hFF, 64'h0102030405060708);
    set_ra(2, 8'h0A);
    cmp(); tick(); clr_wr(); cmp();
    set_wr(1, 8'h0A, 8'h01, 64'h55);
    cmp();
`ifdef FT64_RF_BYPASS_EN
    lit("bypass_now", o[2*WID +: WID], 64'h0102030405060755);
`else
    lit("bypass_now", o[2*WID +: WID], 64'h0102030405060708);
`endif
    tick(); clr_wr(); cmp();
    lit("bypass_after", o[2*WID +: WID], 64'h0102030405060755);

    // randomized traffic over a small address pool to force collisions
    for (int n = 0; n < 3000; n++) begin
      tick();
      for (int p = 0; p < NW; p++) begin
        wr[p] = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 3))
          0: we[p*NB +: NB] = 8'h00;
          1: we[p*NB +: NB] = 8'hFF;
          default: we[p*NB +: NB] = 8'($urandom);
        endcase
        wa[p*AW +: AW] = pool[$urandom_range(0, 7)];
        i[p*WID +: WID] = {$urandom, $urandom};
      end
      for (int k = 0; k < NR; k++) set_ra(k, pool[$urandom_range(0, 7)]);
      if (rst) begin
        rst = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        model_reset();
      end
      cmp();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
